// File: rtl/fft_result_buffer_pkg.sv
// Shared constants, write-FSM state type and size helpers for fft_result_buffer.
// Optional feature macro FRAME_DROP_CNT_EN is consumed by the interface and the top.
package fft_buf_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int HALF_BINS      = 2 ** (ADDR_WIDTH_DEF - 1);
  localparam int FRAME_LEN      = 2 ** ADDR_WIDTH_DEF;
  localparam int DROP_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

  function automatic int half_bins(input int addr_width);
    return 2 ** (addr_width - 1);
  endfunction

  function automatic int frame_len(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/fft_result_buffer_if.sv
// FFT source stream and display read bus for fft_result_buffer.
// drop_count exists only when FRAME_DROP_CNT_EN is defined.
//
// Handshake: there is no backpressure. A sample is transferred on every
// FFT_clk edge where src_valid is high; src_sop/src_eop are meaningful only
// with src_valid. The reader presents one FFT_addr per cycle (always accepted)
// and gets its data on FFT_data_r/i exactly two edges after the address edge.
interface fft_result_buffer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 18
);
  import fft_buf_pkg::*;

  logic                    src_valid;
  logic                    src_sop;
  logic                    src_eop;
  logic [DATA_WIDTH-1:0]   src_real;
  logic [DATA_WIDTH-1:0]   src_imag;
  logic [ADDR_WIDTH-2:0]   FFT_addr;
  logic [DATA_WIDTH-1:0]   FFT_data_r;
  logic [DATA_WIDTH-1:0]   FFT_data_i;
  logic                    done;
`ifdef FRAME_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_count;
`endif

  modport master (
    output src_valid, src_sop, src_eop, src_real, src_imag, FFT_addr,
    input  FFT_data_r, FFT_data_i, done
`ifdef FRAME_DROP_CNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  src_valid, src_sop, src_eop, src_real, src_imag, FFT_addr,
    output FFT_data_r, FFT_data_i, done
`ifdef FRAME_DROP_CNT_EN
    , output drop_count
`endif
  );

endinterface

// File: rtl/fft_result_buffer_bank_ram.sv
// One ping-pong bank: single write port, registered read port, no reset on
// contents so it maps onto block RAM.
module fft_bank_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_result_buffer.sv
// Ping-pong capture of the lower half of each FFT frame with 2-cycle reads.
// Define FRAME_DROP_CNT_EN to add the saturating dropped-frame counter.
module fft_result_buffer
  import fft_buf_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = 18,
  parameter int DONE_CYCLES = 4,
  parameter int LOCK_CYCLES = 2 ** (ADDR_WIDTH - 1) + 8
) (
  input  logic                FFT_clk,
  input  logic                rst,
  fft_result_buffer_if.slave  bus,
  output wr_state_t           o_wr_state
);

  localparam int HB  = half_bins(ADDR_WIDTH);
  localparam int FL  = frame_len(ADDR_WIDTH);
  localparam int RAW = ADDR_WIDTH - 1;
  localparam int RW  = 2 * DATA_WIDTH;
  localparam int LW  = $clog2(LOCK_CYCLES + 1);
  localparam int DCW = $clog2(DONE_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] HB_IDX   = ADDR_WIDTH'(HB);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FL - 1);

  wr_state_t             r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_idx, w_next_idx;
  logic                  w_we;
  logic [RAW-1:0]        w_waddr;
  logic                  w_commit;
  logic                  r_wr_bank;
  logic [LW-1:0]         r_lock;
  logic [DCW-1:0]        r_done_cnt;
  logic [RAW-1:0]        r_raddr;
  logic                  r_sel_p1, r_sel_p2;
  logic [RW-1:0]         w_rdata0, w_rdata1, r_dout;
  logic [RW-1:0]         w_wdata;

  assign w_wdata = {bus.src_real, bus.src_imag};

  // Write FSM. A sop always restarts at bin 0, whatever state we are in.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_we         = 1'b0;
    w_waddr      = r_idx[RAW-1:0];
    w_commit     = 1'b0;
    if (bus.src_valid) begin
      if (bus.src_sop) begin
        w_we         = 1'b1;
        w_waddr      = '0;
        w_next_idx   = ADDR_WIDTH'(1);
        w_next_state = bus.src_eop ? IDLE : CAPTURE;
      end else if (r_state == CAPTURE) begin
        w_we = (r_idx < HB_IDX);
        if (bus.src_eop) begin
          w_commit     = (r_idx == LAST_IDX);
          w_next_state = IDLE;
        end else if (r_idx == LAST_IDX) begin
          w_next_state = DISCARD;
        end else begin
          w_next_idx = r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // A commit while the read bank is still locked leaves the banks alone,
  // so the next frame simply overwrites the same write bank.
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      r_wr_bank  <= 1'b0;
      r_lock     <= '0;
      r_done_cnt <= '0;
    end else if (w_commit && (r_lock == '0)) begin
      r_wr_bank  <= ~r_wr_bank;
      r_lock     <= LW'(LOCK_CYCLES);
      r_done_cnt <= DCW'(DONE_CYCLES);
    end else begin
      if (r_lock != '0)     r_lock     <= r_lock - 1'b1;
      if (r_done_cnt != '0) r_done_cnt <= r_done_cnt - 1'b1;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_commit && (r_lock != '0) && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.drop_count = r_drop_cnt;
`endif

  fft_bank_ram #(.WIDTH(RW), .DEPTH(HB), .AW(RAW)) u_bank0 (
    .i_clk   (FFT_clk),
    .i_we    (w_we && (r_wr_bank == 1'b0)),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata0)
  );

  fft_bank_ram #(.WIDTH(RW), .DEPTH(HB), .AW(RAW)) u_bank1 (
    .i_clk   (FFT_clk),
    .i_we    (w_we && (r_wr_bank == 1'b1)),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata1)
  );

  // The bank choice travels with the address, so a swap only affects
  // reads issued after the commit edge.
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      r_raddr  <= '0;
      r_sel_p1 <= 1'b1;
      r_sel_p2 <= 1'b1;
      r_dout   <= '0;
    end else begin
      r_raddr  <= bus.FFT_addr;
      r_sel_p1 <= ~r_wr_bank;
      r_sel_p2 <= r_sel_p1;
      r_dout   <= r_sel_p2 ? w_rdata1 : w_rdata0;
    end
  end

  assign bus.FFT_data_r = r_dout[RW-1:DATA_WIDTH];
  assign bus.FFT_data_i = r_dout[DATA_WIDTH-1:0];
  assign bus.done       = (r_done_cnt != '0);
  assign o_wr_state     = r_state;

endmodule

// File: tb/tb_fft_result_buffer.sv
// Self-checking bench for fft_result_buffer: frame-level reference model,
// table of frame scenarios, hand sequences for overlap/reset, random phase.
module tb_fft_result_buffer;
  import fft_buf_pkg::*;

  localparam int AW    = 9;
  localparam int DW    = 18;
  localparam int DONE  = 4;
  localparam int LOCK  = 600;
  localparam int HB    = 2 ** (AW - 1);
  localparam int FL    = 2 ** AW;
  localparam int RW    = 2 * DW;

  logic      FFT_clk;
  logic      rst;
  wr_state_t o_wr_state;

  fft_result_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fft_result_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DONE_CYCLES(DONE), .LOCK_CYCLES(LOCK)
  ) dut (
    .FFT_clk    (FFT_clk),
    .rst        (rst),
    .bus        (bus),
    .o_wr_state (o_wr_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial FFT_clk = 1'b0;
  always #5 FFT_clk = ~FFT_clk;

  int cyc = 0;
  always @(posedge FFT_clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  logic [RW-1:0] hist [32][HB];   // every accepted frame, in commit order
  int            hist_t [32];     // cycle count after the commit edge
  int            n_hist = 0;
  int            last_accept = -100000;
  int            reset_cyc = 0;
  int            model_drops = 0;

  logic [RW-1:0] exp_q [$];
  int            due_q [$];
  int            addr_q [$];

  int n_checks = 0;
  int n_err = 0;
  int rises = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which frame does a read issued in cycle c see? The latest one accepted
  // at or before c and after the last reset; none means stale contents.
  function automatic bit lookup(input int c, input int a, output logic [RW-1:0] v);
    int k = -1;
    for (int h = 0; h < n_hist; h++)
      if (hist_t[h] <= c && hist_t[h] > reset_cyc) k = h;
    v = (k >= 0) ? hist[k][a] : '0;
    return (k >= 0);
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge FFT_clk) begin
    logic exp_done;
    exp_done = (cyc >= last_accept) && (cyc - last_accept < DONE);
    chk("done", 64'(bus.done), 64'(exp_done));
    if (bus.done && !prev_done) rises++;
    prev_done = bus.done;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [RW-1:0] e;
      int a;
      e = exp_q.pop_front();
      a = addr_q.pop_front();
      void'(due_q.pop_front());
      chk($sformatf("rd_real[%0d]", a), 64'(bus.FFT_data_r), 64'(e[RW-1:DW]));
      chk($sformatf("rd_imag[%0d]", a), 64'(bus.FFT_data_i), 64'(e[DW-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input bit v, input bit s, input bit e,
                     input logic [DW-1:0] re, input logic [DW-1:0] im);
    bus.src_valid = v;
    bus.src_sop   = s;
    bus.src_eop   = e;
    bus.src_real  = re;
    bus.src_imag  = im;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge FFT_clk);
      put(1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic junk(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge FFT_clk);
      put(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    end
  endtask

  // mode 0: real=bin, imag=-bin; mode 1: random data.
  task automatic drive_frame(input int n, input int eop_at, input int mode, input int gap_pct);
    logic [RW-1:0] cur [HB];
    logic [DW-1:0] re, im;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0)
        while ($urandom_range(0, 99) < gap_pct) begin
          @(negedge FFT_clk);
          put(1'b0, 1'b0, 1'b0, '0, '0);
        end
      @(negedge FFT_clk);
      re = (mode == 0) ? DW'(i)  : DW'($urandom);
      im = (mode == 0) ? DW'(-i) : DW'($urandom);
      put(1'b1, i == 0, i == eop_at, re, im);
      if (i < HB) cur[i] = {re, im};
      if (i == eop_at && i == FL - 1) begin
        if (cyc + 1 - last_accept > LOCK) begin
          hist_t[n_hist] = cyc + 1;
          for (int j = 0; j < HB; j++) hist[n_hist][j] = cur[j];
          n_hist++;
          last_accept = cyc + 1;
        end else if (model_drops < 255) begin
          model_drops++;
        end
      end
    end
  endtask

  task automatic read_addr(input int a);
    logic [RW-1:0] v;
    bus.FFT_addr = (AW-1)'(a);
    if (lookup(cyc, a, v)) begin
      exp_q.push_back(v);
      due_q.push_back(cyc + 3);
      addr_q.push_back(a);
    end
  endtask

  task automatic sweep(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge FFT_clk);
      read_addr(rnd ? int'($urandom_range(0, HB - 1)) : (i % HB));
    end
    repeat (4) @(negedge FFT_clk);
  endtask

  task automatic chk_drops(input string name);
`ifdef FRAME_DROP_CNT_EN
    chk(name, 64'(bus.drop_count), 64'(model_drops));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int        n;
    int        eop_at;
    int        junk_n;
    int        idle_n;
    int        mode;
    int        pulses;
    int        drops;
    wr_state_t st;
    bit        do_sweep;
  } vec_t;

  vec_t tbl [10];

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    tbl[0] = '{512, 511, 0,  5, 0, 1, 0, IDLE,    1'b0}; // first frame, bin pattern
    tbl[1] = '{512, 511, 0,  5, 1, 0, 1, IDLE,    1'b1}; // 517 after: dropped, reads frame 0
    tbl[2] = '{301, 300, 3,  5, 1, 0, 1, IDLE,    1'b0}; // eop at 300: malformed
    tbl[3] = '{600,  -1, 4, 10, 1, 0, 1, DISCARD, 1'b0}; // overlong: discard
    tbl[4] = '{512, 511, 0,  5, 1, 1, 1, IDLE,    1'b1}; // proper frame after discard
    tbl[5] = '{200,  -1, 0,  1, 1, 0, 1, CAPTURE, 1'b0}; // aborted by next sop
    tbl[6] = '{512, 511, 0, 88, 1, 1, 1, IDLE,    1'b0}; // restarted frame commits
    tbl[7] = '{512, 511, 0,  5, 1, 0, 2, IDLE,    1'b1}; // exactly LOCK later: dropped
    tbl[8] = '{512, 511, 0, 89, 1, 1, 2, IDLE,    1'b0};
    tbl[9] = '{512, 511, 0, 10, 1, 1, 2, IDLE,    1'b1}; // LOCK+1 later: accepted

    rst = 1'b0;
    put(1'b0, 1'b0, 1'b0, '0, '0);
    bus.FFT_addr = '0;
    repeat (3) @(negedge FFT_clk);
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_data_r", 64'(bus.FFT_data_r), 64'(0));
    chk("reset_data_i", 64'(bus.FFT_data_i), 64'(0));
    chk("reset_state", 64'(o_wr_state), 64'(IDLE));
    chk_drops("reset_drop_count");
    rst = 1'b1;
    reset_cyc = cyc;
    idle(3);

    for (int e = 0; e < 10; e++) begin
      r0 = rises;
      drive_frame(tbl[e].n, tbl[e].eop_at, tbl[e].mode, 0);
      junk(tbl[e].junk_n);
      idle(tbl[e].idle_n);
      chk($sformatf("t%0d_state", e), 64'(o_wr_state), 64'(tbl[e].st));
      if (tbl[e].do_sweep) sweep(HB, 1'b0);
      chk($sformatf("t%0d_done_pulses", e), 64'(rises - r0), 64'(tbl[e].pulses));
      chk_drops($sformatf("t%0d_drop_count", e));
    end

    // Overlap: frame B streams while frame A is swept.
    r0 = rises;
    drive_frame(FL, FL - 1, 1, 0);
    idle(5);
    fork
      sweep(HB, 1'b0);
      begin
        idle(120);
        drive_frame(FL, FL - 1, 1, 0);
        idle(10);
      end
    join
    idle(5);
    sweep(HB, 1'b1);
    chk("overlap_done_pulses", 64'(rises - r0), 64'(2));

    // Reset in the middle of a frame at sample 150.
    idle(5);
    for (int i = 0; i < 150; i++) begin
      @(negedge FFT_clk);
      put(1'b1, i == 0, 1'b0, DW'(i), DW'(-i));
    end
    @(negedge FFT_clk);
    put(1'b1, 1'b0, 1'b0, DW'(150), DW'(-150));
    rst = 1'b0;
    @(negedge FFT_clk);
    rst = 1'b1;
    put(1'b0, 1'b0, 1'b0, '0, '0);
    reset_cyc   = cyc;
    last_accept = -100000;
    model_drops = 0;
    chk("midrst_done", 64'(bus.done), 64'(0));
    chk("midrst_data_r", 64'(bus.FFT_data_r), 64'(0));
    chk("midrst_data_i", 64'(bus.FFT_data_i), 64'(0));
    chk("midrst_state", 64'(o_wr_state), 64'(IDLE));
    chk_drops("midrst_drop_count");
    r0 = rises;
    drive_frame(FL, FL - 1, 0, 0);
    idle(10);
    chk("post_rst_done_pulses", 64'(rises - r0), 64'(1));
    sweep(HB, 1'b0);

    // Random phase: mixed frame kinds with valid gaps, concurrent random reads.
    fork
      for (int r = 0; r < 8; r++) begin
        int kind, n, eop_at;
        kind = $urandom_range(0, 3);
        case (kind)
          0:       begin n = FL; eop_at = FL - 1; end
          1:       begin eop_at = $urandom_range(1, FL - 2); n = eop_at + 1; end
          2:       begin n = FL + $urandom_range(0, 40); eop_at = -1; end
          default: begin n = $urandom_range(1, FL - 1); eop_at = -1; end
        endcase
        drive_frame(n, eop_at, 1, 20);
        if (kind != 3) junk($urandom_range(0, 4));
        idle($urandom_range(1, 300));
      end
      for (int i = 0; i < 2000; i++) begin
        @(negedge FFT_clk);
        if ($urandom_range(0, 1) == 1) read_addr($urandom_range(0, HB - 1));
      end
    join
    idle(10);
    chk_drops("random_drop_count");
    chk("queue_drained", 64'(due_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "bench timeout");
  end

endmodule
